// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store
// port (priority) and an external burst requester with starvation protection.
module dmem_arbiter #(
  parameter int unsigned AW           = 12,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_mem_en,
  input  logic          cpu_mem_rd,
  input  logic          cpu_mem_wr,
  input  logic [AW-1:0] cpu_mem_addr,
  input  logic [DW-1:0] cpu_mem_wdata,
  output logic [DW-1:0] cpu_mem_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_wr,
  input  logic [AW-1:0] ext_addr,
  input  logic [3:0]    ext_len,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_beat_ack,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rdata_vld,
  output logic          ext_busy,
  output logic          ext_done,
  output logic          mem_en,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] base;
  logic [CW-1:0] len;
  logic          wr;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] starve_cnt;
  logic          rd_pend;

  logic          accept;
  logic          ext_beat;
  logic          cpu_win;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, arbitration and memory-port mux
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    ext_beat      = 1'b0;
    cpu_stall     = (state == S_ACTIVE) && (starve_cnt == CW'(STARVE_LIMIT));
    ext_busy      = (state != S_IDLE);
    ext_done      = (state == S_DRAIN);
    ext_rdata_vld = rd_pend;
    ext_rdata     = mem_rdata;
    cpu_mem_rdata = mem_rdata;

    case (state)
      S_IDLE: begin
        if (ext_req) begin
          accept    = 1'b1;
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        ext_beat = (!cpu_mem_en || cpu_stall) && !reset;
        if (ext_beat && (beat_cnt == len)) state_nxt = S_DRAIN;
      end
      S_DRAIN:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    cpu_win      = cpu_mem_en && !ext_beat && !reset;
    ext_beat_ack = ext_beat;

    if (ext_beat) begin
      mem_en    = 1'b1;
      mem_rd    = !wr;
      mem_wr    = wr;
      mem_addr  = base + AW'(beat_cnt);
      mem_wdata = ext_wdata;
    end else begin
      // Idle cycles still present the CPU address/data; only the strobes drop.
      mem_en    = cpu_win;
      mem_wr    = cpu_win && cpu_mem_wr;
      mem_rd    = cpu_win && cpu_mem_rd && !cpu_mem_wr;
      mem_addr  = cpu_mem_addr;
      mem_wdata = cpu_mem_wdata;
    end
  end

  // Burst bookkeeping: latched request, beat and starvation counters
  always_ff @(posedge clk) begin
    if (reset) begin
      base       <= '0;
      len        <= '0;
      wr         <= 1'b0;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
    end else begin
      rd_pend <= ext_beat && !wr;
      if (accept) begin
        base       <= ext_addr;
        len        <= ext_len;
        wr         <= ext_wr;
        beat_cnt   <= '0;
        starve_cnt <= '0;
      end else if (ext_beat) begin
        beat_cnt   <= beat_cnt + CW'(1);
        starve_cnt <= '0;
      end else if ((state == S_ACTIVE) && cpu_win &&
                   (starve_cnt != CW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 4K x 8 data memory between the execute unit's load/store port (CPU) and an external burst requester (loader/debug DMA). The CPU has priority, but a starvation counter guarantees the external burst forward progress by stalling the CPU for one slot. The block sits between the execute unit's d_mem_* signals and the data memory macro. It sequences each external burst with an auto-incrementing address and beat counter.

## Interface
- AW, 12, memory address width
- DW, 8, memory data width
- STARVE_LIMIT, 8, consecutive blocked ext cycles before a forced ext slot (1..15)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_mem_en / cpu_mem_rd / cpu_mem_wr  in  1 each  CPU access request, single-cycle, from execute
- cpu_mem_addr  in  AW  CPU address
- cpu_mem_wdata  in  DW  CPU store data
- cpu_mem_rdata  out  DW  load data; equals mem_rdata
- cpu_stall  out  1  CPU access this cycle not issued; execute must hold it
- ext_req  in  1  burst request, sampled only in IDLE
- ext_wr  in  1  1 = write burst, 0 = read burst
- ext_addr  in  AW  burst base address
- ext_len  in  4  beats minus one (0 → 1 beat, 15 → 16 beats)
- ext_wdata  in  DW  current write beat data
- ext_beat_ack  out  1  current ext beat issued; requester advances ext_wdata next cycle
- ext_rdata  out  DW  read beat data; equals mem_rdata
- ext_rdata_vld  out  1  ext_rdata valid
- ext_busy  out  1  burst accepted and not finished
- ext_done  out  1  one-cycle burst-complete pulse
- mem_en / mem_rd / mem_wr  out  1 each  memory strobes
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read strobe

## Operation
- FSM states: IDLE, ACTIVE, DRAIN. Registers: base (AW), len (4), wr (1), beat_cnt (4), starve_cnt (4), rd_pend (1).
- IDLE:
  - If ext_req, latch ext_addr, ext_len, ext_wr, clear beat_cnt and starve_cnt, and go to ACTIVE.
  - No ext beat is issued in the accept cycle.
- cpu_stall = (state == ACTIVE) && (starve_cnt == STARVE_LIMIT). It depends only on registers.
- Ext beat issue condition: ACTIVE && (!cpu_mem_en || cpu_stall).
- On an ext beat:
  - mem_en=1, mem_rd=!wr, mem_wr=wr.
  - mem_addr = base + beat_cnt, modulo 2^AW (wraps 0xFFF→0x000).
  - mem_wdata = ext_wdata, ext_beat_ack=1, beat_cnt++, starve_cnt cleared.
  - On the last beat (beat_cnt == len), go to DRAIN.
- When the CPU wins a cycle:
  - mem_* = cpu_mem_*; ext_beat_ack=0.
  - If ACTIVE, starve_cnt++ (saturates at STARVE_LIMIT).
- CPU strobes with cpu_mem_rd && cpu_mem_wr set: write wins, rd is suppressed.
- No CPU request and no ext beat: mem_en/rd/wr = 0; mem_addr and mem_wdata hold the CPU values.
- rd_pend is set the cycle after an ext read beat, so ext_rdata_vld = rd_pend.
- DRAIN lasts one cycle:
  - ext_done=1; the last read beat's ext_rdata_vld coincides with it.
  - ext_req is ignored; return to IDLE.
- ext_busy = (state != IDLE).
- Reset: state IDLE, all counters 0, rd_pend 0. Any in-flight burst is aborted with no ext_done.
- While reset is high, mem_en/rd/wr are forced to 0.

## Timing
- Reset values: cpu_stall 0, ext_beat_ack 0, ext_rdata_vld 0, ext_busy 0, ext_done 0, mem_en/rd/wr 0. Data outputs follow their mux sources.
- The CPU path is combinational: zero added latency, read data in cycle N+1.
- Ext burst accepted at cycle A. The first possible beat is A+1. With no CPU traffic, beat k issues at A+1+k, DRAIN is at A+len+2, and ext_done is at A+len+2.
- Ext read data for the beat issued at cycle N is on ext_rdata with ext_rdata_vld at cycle N+1.
- Worst-case ext beat latency under continuous CPU traffic: STARVE_LIMIT+1 cycles.
- A cpu_stall cycle always carries an ext beat. The held CPU access issues the following cycle unless it is again blocked, which cannot happen because starve_cnt is 0.
- A new ext_req can be accepted in the IDLE cycle right after DRAIN, giving a 2-cycle gap between bursts.

## Test plan
- Idle CPU, ext read burst base 0x100, len 3 → beats at A+1..A+4 on addresses 0x100..0x103; ext_rdata_vld A+2..A+5; ext_done at A+5; ext_busy A+1..A+5.
- Ext write burst base 0xFFE, len 2, CPU idle → mem_wr to 0xFFE, 0xFFF, 0x000 with ext_wdata; 3 ext_beat_ack pulses; ext_done once.
- Continuous CPU loads during an ext burst, STARVE_LIMIT=8 → 8 CPU slots, then one cpu_stall cycle carrying an ext beat, then the held CPU load issues; the pattern repeats per beat.
- CPU access only in the burst-accept cycle → CPU issued, no stall, first ext beat the next cycle.
- Reset asserted mid-burst after 2 of 6 beats → next cycle IDLE, ext_busy 0, no ext_done, mem_en 0. A fresh burst afterwards starts at its own base.
- cpu_mem_rd and cpu_mem_wr both high, no ext → mem_wr=1, mem_rd=0.
